voice_digit_display_ctrl: RTL and testbench
===========================================

# voice_digit_display_ctrl

Parametrised successor to the single-number voice-ID → 7-segment path. It accepts a stream of 6-bit voice-command IDs and buffers up to DEPTH decoded digits. It drives a time-multiplexed, active-low DIGITS-wide 7-segment display, scrolling when more digits are recorded than fit. The block sits between the voice-recognition front end and the board display pins, in parallel with the address-map/memory blocks under Top.

## Interface
- DIGITS, 4, number of physical display digits (≥2)
- DEPTH, 8, digit buffer entries (≥DIGITS, power of 2 not required)
- REFRESH_DIV, 50000, clk cycles per multiplexed digit slot (≥1)
- SCROLL_DIV, 25000000, clk cycles per scroll step in DONE (≥1)
- clk  in  1  system clock; all logic on rising edge
- nRESET  in  1  asynchronous, active-low reset
- ID  in  6  voice command/number ID
- id_valid  in  1  one-cycle strobe; ID is sampled only when high
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- an_n  out  DIGITS  digit enables, active-low, one-hot-low, registered; bit DIGITS-1 = leftmost
- state  out  2  00 IDLE, 01 START, 10 DONE
- digit_count  out  $clog2(DEPTH+1)  digits held
- overflow  out  1  sticky: a digit was dropped because the buffer was full

## Operation
- ID classes: 0 = CLEAR; 5 = START; 46 = END; 47 = AGAIN; 8..45 = NUMBER, digit = (ID−8) mod 10; all other IDs are ignored.
- CLEAR in any state → IDLE, count=0, overflow=0, scroll index=0. CLEAR has priority over everything.
- IDLE: START → START state, count=0, overflow=0. Other classes are ignored.
- START: NUMBER with count<DEPTH → buf[count]=digit, count+1. NUMBER with count==DEPTH → dropped, overflow=1. END → DONE, scroll index=0. START/AGAIN are ignored.
- DONE: AGAIN → START, count=0, overflow=0. NUMBER/START/END are ignored.
- Display content, where position p = 0 is the leftmost of DIGITS:
  - IDLE: all positions blank.
  - START or DONE with count ≤ DIGITS: right-aligned. Position p shows buf[p−(DIGITS−count)]; positions with p < DIGITS−count are blank.
  - START with count > DIGITS: shows the last DIGITS entries, i.e. p shows buf[count−DIGITS+p].
  - DONE with count > DIGITS: p shows buf[(sidx+p) mod count]. sidx increments every SCROLL_DIV cycles and wraps from count−1 to 0.
- Segment codes (hex, active-low gfedcba): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Multiplexing: a refresh counter runs 0..REFRESH_DIV−1. On wrap, the slot index advances DIGITS−1 → … → 0 → DIGITS−1. The active slot k drives an_n[k]=0 and seg_n = code for position DIGITS−1−k.

## Timing
- Reset (nRESET=0, asynchronous) drives:
  - state=IDLE, count=0, overflow=0, sidx=0
  - refresh and scroll counters = 0, slot = DIGITS−1
  - seg_n=7'h7F, an_n = all ones
- A reset asserted mid-record or mid-scroll discards all buffered digits.
- When id_valid=1 at edge t, the effects on state, count, overflow and the buffer are visible after edge t; seg_n/an_n reflect them by edge t+1.
- Back-to-back id_valid strobes on consecutive cycles are each processed; none are lost.
- seg_n and an_n change together on the same edge. There is no cycle with two an_n bits low.
- The scroll counter runs only in DONE with count > DIGITS. It is cleared on any state change.
- END with count=0 enters DONE with all positions blank.

## Test plan
- Reset → seg_n=7F, an_n=F, state=00, count=0. After release with no IDs, the display stays blank for 4 slots.
- ID 5, 13, 35, 44, 46 (DIGITS=4, REFRESH_DIV=2) → state=10, count=3. Slots in order show blank, 12(5), 78(7), 02(6), left to right.
- Continue with 47, 30, 38, 46 → count resets to 0 on 47 and ends at 2. Display shows blank, blank, 24(2), 40(0). Then ID 0 → state=00, all blank.
- ID 5 then digits 1..6 (IDs 9..14), 46 with SCROLL_DIV=8 → the window starts at 1 2 3 4. Every 8 cycles it shifts to 2 3 4 5, then 3 4 5 6, then 4 5 6 1 (wrap).
- DEPTH=8: ID 5 then 10 NUMBER IDs → count=8, overflow=1, and the first 8 digits are retained. ID 46, 47 → overflow=0, count=0.
- Assert nRESET low mid-START with count=2, asynchronously between edges → outputs go to reset values immediately. Ignored IDs 3 and 47 sent in IDLE → no state change.

Source files
------------

// File: rtl/voice_digit_display_ctrl.sv
// rtl/voice_digit_display_ctrl.sv - voice-ID digit recorder driving a multiplexed active-low 7-segment display
//
// Ports:
//   clk          system clock, rising edge
//   nRESET       asynchronous active-low reset
//   ID           6-bit voice command/number ID, sampled when id_valid is high
//   id_valid     one-cycle strobe qualifying ID
//   seg_n        registered segments {g,f,e,d,c,b,a}, active-low
//   an_n         registered digit enables, active-low one-hot, bit DIGITS-1 = leftmost
//   state        00 IDLE, 01 START, 10 DONE
//   digit_count  number of digits held in the buffer
//   overflow     sticky flag: a digit was dropped because the buffer was full
module voice_digit_display_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DEPTH       = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25000000
) (
  input  logic                         clk,
  input  logic                         nRESET,
  input  logic [5:0]                   ID,
  input  logic                         id_valid,
  output logic [6:0]                   seg_n,
  output logic [DIGITS-1:0]            an_n,
  output logic [1:0]                   state,
  output logic [$clog2(DEPTH+1)-1:0]   digit_count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DIGITS);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t        st_q, st_d;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [3:0]    digit_buf [DEPTH];
  logic [CW-1:0] sidx_q;
  logic [TW-1:0] scroll_cnt_q;
  logic [RW-1:0] refresh_cnt_q;
  logic [SW-1:0] slot_q, slot_d;

  logic          is_clear, is_start, is_end, is_again, is_num;
  logic [5:0]    id_off;
  logic [3:0]    num_digit;
  logic          state_chg, scrolling, refresh_wrap, do_store;
  logic [CW:0]   pos, cnt_x, rd_idx;
  logic          show;
  logic [6:0]    seg_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // ID classification; id_off wraps for IDs below 8 but is then unused
  always_comb begin
    is_clear  = id_valid && (ID == 6'd0);
    is_start  = id_valid && (ID == 6'd5);
    is_end    = id_valid && (ID == 6'd46);
    is_again  = id_valid && (ID == 6'd47);
    is_num    = id_valid && (ID >= 6'd8) && (ID <= 6'd45);
    id_off    = ID - 6'd8;
    num_digit = 4'(id_off % 6'd10);
  end

  always_comb begin
    st_d = st_q;
    if (is_clear) begin
      st_d = S_IDLE;
    end else begin
      case (st_q)
        S_IDLE:  if (is_start) st_d = S_START;
        S_START: if (is_end)   st_d = S_DONE;
        S_DONE:  if (is_again) st_d = S_START;
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) st_q <= S_IDLE;
    else         st_q <= st_d;
  end

  assign state_chg = (st_d != st_q);
  assign scrolling = (st_q == S_DONE) && (count_q > CW'(DIGITS));
  assign do_store  = (st_q == S_START) && is_num && (count_q < CW'(DEPTH));

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      count_q      <= '0;
      ovf_q        <= 1'b0;
      sidx_q       <= '0;
      scroll_cnt_q <= '0;
    end else begin
      if (is_clear || (st_q == S_IDLE && is_start) || (st_q == S_DONE && is_again)) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (do_store) begin
        count_q <= count_q + CW'(1);
      end else if (st_q == S_START && is_num) begin
        ovf_q <= 1'b1;
      end
      // scroll position restarts whenever the state changes
      if (state_chg || is_clear) begin
        scroll_cnt_q <= '0;
        sidx_q       <= '0;
      end else if (scrolling) begin
        if (scroll_cnt_q == TW'(SCROLL_DIV - 1)) begin
          scroll_cnt_q <= '0;
          sidx_q       <= (sidx_q == count_q - CW'(1)) ? '0 : sidx_q + CW'(1);
        end else begin
          scroll_cnt_q <= scroll_cnt_q + TW'(1);
        end
      end
    end
  end

  // buffer contents need no reset: count_q alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_store) digit_buf[AW'(count_q)] <= num_digit;
  end

  assign refresh_wrap = (refresh_cnt_q == RW'(REFRESH_DIV - 1));

  // seg_n is computed for the slot that becomes active on this edge, so
  // seg_n and an_n always switch together
  always_comb begin
    slot_d = slot_q;
    if (refresh_wrap) slot_d = (slot_q == '0) ? SW'(DIGITS - 1) : slot_q - SW'(1);
    pos    = (CW+1)'(DIGITS - 1) - (CW+1)'(slot_d);
    cnt_x  = (CW+1)'(count_q);
    rd_idx = '0;
    show   = 1'b0;
    if (st_q != S_IDLE) begin
      if (cnt_x <= (CW+1)'(DIGITS)) begin
        // right-aligned: leading positions are blank
        if (pos + cnt_x >= (CW+1)'(DIGITS)) begin
          show   = 1'b1;
          rd_idx = pos + cnt_x - (CW+1)'(DIGITS);
        end
      end else if (st_q == S_START) begin
        show   = 1'b1;
        rd_idx = cnt_x - (CW+1)'(DIGITS) + pos;
      end else begin
        show   = 1'b1;
        rd_idx = (CW+1)'(sidx_q) + pos;
        if (rd_idx >= cnt_x) rd_idx = rd_idx - cnt_x;
      end
    end
    seg_d = show ? seg_code(digit_buf[AW'(rd_idx)]) : 7'h7F;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      refresh_cnt_q <= '0;
      slot_q        <= SW'(DIGITS - 1);
      seg_n         <= 7'h7F;
      an_n          <= '1;
    end else begin
      refresh_cnt_q <= refresh_wrap ? '0 : refresh_cnt_q + RW'(1);
      slot_q        <= slot_d;
      seg_n         <= seg_d;
      an_n          <= ~(DIGITS'(1) << slot_d);
    end
  end

  assign state       = st_q;
  assign digit_count = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_voice_digit_display_ctrl.sv
// tb/tb_voice_digit_display_ctrl.sv - self-checking bench for voice_digit_display_ctrl
module tb_voice_digit_display_ctrl;

  localparam int DIGITS      = 4;
  localparam int DEPTH       = 8;
  localparam int REFRESH_DIV = 2;
  localparam int SCROLL_DIV  = 8;

  logic       clk = 1'b0;
  logic       nRESET;
  logic [5:0] ID;
  logic       id_valid;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic [1:0] state;
  logic [3:0] digit_count;
  logic       overflow;

  voice_digit_display_ctrl #(
    .DIGITS(DIGITS), .DEPTH(DEPTH), .REFRESH_DIV(REFRESH_DIV), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk(clk), .nRESET(nRESET), .ID(ID), .id_valid(id_valid),
    .seg_n(seg_n), .an_n(an_n), .state(state),
    .digit_count(digit_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: state 0 idle, 1 start, 2 done
  int m_state;
  int m_q[$];
  int m_ovf;
  int m_done_k;
  int edges;
  int exp_disp[DIGITS];
  int obs_pos;
  int obs_seg;
  int seg_tab[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  typedef struct {
    logic       v;
    logic [5:0] id;
    int         st;
    int         cnt;
    int         ovf;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state  = 0;
    m_q.delete();
    m_ovf    = 0;
    m_done_k = 0;
  endtask

  function automatic int m_seg(int p);
    int n;
    int idx;
    n = m_q.size();
    if (m_state == 0) return 'h7F;
    if (n <= DIGITS) begin
      if (p < DIGITS - n) return 'h7F;
      idx = p - (DIGITS - n);
    end else if (m_state == 1) begin
      idx = n - DIGITS + p;
    end else begin
      idx = ((m_done_k / SCROLL_DIV) % n + p) % n;
    end
    return seg_tab[m_q[idx]];
  endfunction

  task automatic m_apply(input logic v, input logic [5:0] id);
    int prev;
    prev = m_state;
    if (v) begin
      if (id == 0) begin
        m_state = 0; m_q.delete(); m_ovf = 0;
      end else if (m_state == 0 && id == 5) begin
        m_state = 1; m_q.delete(); m_ovf = 0;
      end else if (m_state == 1 && id >= 8 && id <= 45) begin
        if (m_q.size() < DEPTH) m_q.push_back((int'(id) - 8) % 10);
        else m_ovf = 1;
      end else if (m_state == 1 && id == 46) begin
        m_state = 2;
      end else if (m_state == 2 && id == 47) begin
        m_state = 1; m_q.delete(); m_ovf = 0;
      end
    end
    if (m_state == 2) m_done_k = (prev == 2) ? m_done_k + 1 : 0;
  endtask

  // one clock: drive at negedge, snapshot expected display, check after posedge
  task automatic step(input logic v, input logic [5:0] id);
    int es;
    logic [3:0] exp_an;
    @(negedge clk);
    id_valid = v;
    ID       = id;
    for (int p = 0; p < DIGITS; p++) exp_disp[p] = m_seg(p);
    @(posedge clk);
    #1;
    m_apply(v, id);
    edges++;
    es      = DIGITS - 1 - (edges / REFRESH_DIV) % DIGITS;
    exp_an  = ~(4'b0001 << es);
    obs_pos = DIGITS - 1 - es;
    obs_seg = int'(seg_n);
    check("an_n", 32'(an_n), 32'(exp_an));
    check("seg_n", 32'(seg_n), 32'(exp_disp[obs_pos]));
    check("state", 32'(state), 32'(m_state));
    check("digit_count", 32'(digit_count), 32'(m_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic add(input logic v, input logic [5:0] id, input int st, input int cnt, input int ovf);
    vec_t e;
    e.v = v; e.id = id; e.st = st; e.cnt = cnt; e.ovf = ovf;
    tbl.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
    check({tag, "_an_n"}, 32'(an_n), 32'hF);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_count"}, 32'(digit_count), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  int win[4][4] = '{'{'h79, 'h24, 'h30, 'h19},
                    '{'h24, 'h30, 'h19, 'h12},
                    '{'h30, 'h19, 'h12, 'h02},
                    '{'h19, 'h12, 'h02, 'h79}};
  int got[4][4];

  initial begin
    nRESET = 1'b0; id_valid = 1'b0; ID = 6'd0;
    m_reset();
    edges = 0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #2;
    nRESET = 1'b1;
    edges  = 0;
    // valid low with a START ID: must be ignored, display blank
    repeat (8) step(1'b0, 6'd5);

    // table: inputs and expected state/count/overflow
    add(1, 5, 1, 0, 0);  add(1, 13, 1, 1, 0); add(1, 35, 1, 2, 0);
    add(1, 44, 1, 3, 0); add(1, 46, 2, 3, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 2, 3, 0);
    add(1, 47, 1, 0, 0); add(1, 30, 1, 1, 0); add(1, 38, 1, 2, 0); add(1, 46, 2, 2, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 2, 2, 0);
    add(1, 0, 0, 0, 0);  add(1, 3, 0, 0, 0);  add(1, 47, 0, 0, 0); add(1, 46, 0, 0, 0);
    add(1, 5, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 6'(8 + i), 1, (i < 8) ? i + 1 : 8, (i >= 8) ? 1 : 0);
    add(1, 46, 2, 8, 1);
    for (int i = 0; i < 16; i++) add(0, 0, 2, 8, 1);
    add(1, 5, 2, 8, 1);  add(1, 20, 2, 8, 1); add(1, 47, 1, 0, 0);
    add(1, 46, 2, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].id);
      check("tbl_state", 32'(state), 32'(tbl[i].st));
      check("tbl_count", 32'(digit_count), 32'(tbl[i].cnt));
      check("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
    end

    // scroll: digits 1..6, four windows of SCROLL_DIV cycles each
    step(1, 6'd5);
    for (int d = 1; d <= 6; d++) step(1, 6'(8 + d));
    step(1, 6'd46);
    for (int w = 0; w < 4; w++)
      for (int c = 0; c < 8; c++) begin
        step(0, 6'd0);
        got[w][obs_pos] = obs_seg;
      end
    for (int w = 0; w < 4; w++)
      for (int p = 0; p < 4; p++)
        check($sformatf("scroll_w%0d_p%0d", w, p), 32'(got[w][p]), 32'(win[w][p]));
    step(1, 6'd0);

    // asynchronous reset between edges while recording
    step(1, 6'd5); step(1, 6'd9); step(1, 6'd10);
    check("pre_reset_count", 32'(digit_count), 32'd2);
    @(negedge clk);
    id_valid = 1'b0;
    #2;
    nRESET = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_reset();
    @(posedge clk); #2;
    nRESET = 1'b1;
    edges  = 0;
    step(1, 6'd3); step(1, 6'd47);
    check("ignored_in_idle", 32'(state), 32'd0);
    repeat (4) step(0, 6'd0);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [5:0] rid;
      r = int'($urandom_range(0, 19));
      if (r == 0)       rid = 6'd0;
      else if (r < 4)   rid = 6'd5;
      else if (r < 6)   rid = 6'd46;
      else if (r < 7)   rid = 6'd47;
      else if (r < 17)  rid = 6'($urandom_range(8, 45));
      else              rid = 6'($urandom_range(0, 63));
      step(($urandom_range(0, 2) == 0), rid);
    end

    id_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
